// File: rtl/bcp_clause_scanner.sv
// Sequential BCP clause scanner: classifies a bank of clauses against a latched assignment snapshot.
// Optional macro BCP_STATS_EN adds stat_unit_cnt / stat_sat_cnt counters.
module bcp_clause_scanner #(
  parameter int VAR_NUM    = 8,
  parameter int CLAUSE_NUM = 16,
  parameter int VIDX_W     = $clog2(VAR_NUM),
  parameter int CIDX_W     = $clog2(CLAUSE_NUM)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cl_we,
  input  logic [CIDX_W-1:0]  cl_addr,
  input  logic [VAR_NUM-1:0] cl_type,
  input  logic [VAR_NUM-1:0] cl_mask,
  input  logic [VAR_NUM-1:0] asg_val,
  input  logic [VAR_NUM-1:0] asg_valid,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               all_sat,
  output logic               conflict,
  output logic [CIDX_W-1:0]  conflict_clause,
`ifdef BCP_STATS_EN
  output logic [CIDX_W:0]    stat_unit_cnt,
  output logic [CIDX_W:0]    stat_sat_cnt,
`endif
  output logic               imp_valid,
  input  logic               imp_ready,
  output logic [VIDX_W-1:0]  imp_var,
  output logic               imp_val,
  output logic [CIDX_W-1:0]  imp_clause
);

  localparam logic [CIDX_W-1:0] LAST = CIDX_W'(CLAUSE_NUM - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_IMPLY, ST_DONE} state_t;
  typedef enum logic [2:0] {CL_DIS, CL_SAT, CL_CONF, CL_UNIT, CL_UNDEC} cls_t;

  state_t state, state_d;
  cls_t   cls;

  logic [CLAUSE_NUM-1:0][VAR_NUM-1:0] bank_type, bank_mask;
  logic [VAR_NUM-1:0] snap_val, snap_vld;
  logic [VAR_NUM-1:0] cur_type, cur_mask;
  logic [VAR_NUM-1:0] lit_true, lit_open;
  logic [CIDX_W-1:0]  eidx, nxt_idx;
  logic [VIDX_W-1:0]  open_idx;
  logic               cur_vld, run_sat;
  logic               start_acc, fetch, adv, go_imp, go_conf, last, scanning, clr_sat;

  assign busy     = (state == ST_SCAN) || (state == ST_IMPLY);
  assign done     = (state == ST_DONE);
  assign last     = (eidx == LAST);
  assign scanning = (state == ST_SCAN) && cur_vld;
  assign clr_sat  = scanning && ((cls == CL_UNIT) || (cls == CL_UNDEC));
  // The bank is read through a one-slot fetch register; eidx is the clause being evaluated.
  assign nxt_idx  = cur_vld ? eidx + CIDX_W'(1) : '0;

  for (genvar i = 0; i < VAR_NUM; i++) begin : g_lane
    assign lit_true[i] = cur_mask[i] & snap_vld[i] & (snap_val[i] == cur_type[i]);
    assign lit_open[i] = cur_mask[i] & ~snap_vld[i];
  end

  always_comb begin
    if (cur_mask == '0)                                       cls = CL_DIS;
    else if (|lit_true)                                       cls = CL_SAT;
    else if (lit_open == '0)                                  cls = CL_CONF;
    else if ((lit_open & (lit_open - VAR_NUM'(1))) == '0)     cls = CL_UNIT;
    else                                                      cls = CL_UNDEC;
  end

  always_comb begin
    open_idx = '0;
    for (int i = VAR_NUM - 1; i >= 0; i--)
      if (lit_open[i]) open_idx = VIDX_W'(i);
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= ST_IDLE;
    else       state <= state_d;

  always_comb begin
    state_d   = state;
    start_acc = 1'b0;
    fetch     = 1'b0;
    adv       = 1'b0;
    go_imp    = 1'b0;
    go_conf   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE:
        if (start) begin
          state_d   = ST_SCAN;
          start_acc = 1'b1;
        end
      ST_SCAN:
        if (!cur_vld) fetch = 1'b1;
        else begin
          case (cls)
            CL_UNIT: begin go_imp  = 1'b1; state_d = ST_IMPLY; end
            CL_CONF: begin go_conf = 1'b1; state_d = ST_DONE;  end
            default: adv = 1'b1;
          endcase
        end
      ST_IMPLY:
        if (imp_valid && imp_ready) adv = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      if (last) state_d = ST_DONE;
      else begin
        state_d = ST_SCAN;
        fetch   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bank_type <= '0;
      bank_mask <= '0;
    end else if (cl_we && !busy) begin
      bank_type[cl_addr] <= cl_type;
      bank_mask[cl_addr] <= cl_mask;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      snap_val        <= '0;
      snap_vld        <= '0;
      cur_type        <= '0;
      cur_mask        <= '0;
      cur_vld         <= 1'b0;
      eidx            <= '0;
      run_sat         <= 1'b0;
      all_sat         <= 1'b0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
      imp_valid       <= 1'b0;
      imp_var         <= '0;
      imp_val         <= 1'b0;
      imp_clause      <= '0;
    end else begin
      if (start_acc) begin
        snap_val        <= asg_val;
        snap_vld        <= asg_valid;
        cur_vld         <= 1'b0;
        eidx            <= '0;
        run_sat         <= 1'b1;
        all_sat         <= 1'b0;
        conflict        <= 1'b0;
        conflict_clause <= '0;
        imp_valid       <= 1'b0;
      end
      if (fetch) begin
        cur_type <= bank_type[nxt_idx];
        cur_mask <= bank_mask[nxt_idx];
        eidx     <= nxt_idx;
        cur_vld  <= 1'b1;
      end
      if (clr_sat) run_sat <= 1'b0;
      if (go_imp) begin
        imp_valid  <= 1'b1;
        imp_var    <= open_idx;
        imp_val    <= cur_type[open_idx];
        imp_clause <= eidx;
      end
      if ((state == ST_IMPLY) && imp_valid && imp_ready) imp_valid <= 1'b0;
      if (go_conf) begin
        conflict        <= 1'b1;
        conflict_clause <= eidx;
      end
      // Last clause may itself clear the running flag on this same edge.
      if (adv && last) all_sat <= run_sat & ~clr_sat;
    end

`ifdef BCP_STATS_EN
  localparam int SW = CIDX_W + 1;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      stat_unit_cnt <= '0;
      stat_sat_cnt  <= '0;
    end else if (start_acc) begin
      stat_unit_cnt <= '0;
      stat_sat_cnt  <= '0;
    end else if (scanning) begin
      if (cls == CL_UNIT) stat_unit_cnt <= stat_unit_cnt + SW'(1);
      if (cls == CL_SAT)  stat_sat_cnt  <= stat_sat_cnt + SW'(1);
    end
`endif

endmodule

// File: tb/tb_bcp_clause_scanner.sv
// Self-checking bench for bcp_clause_scanner: vector table plus implication scoreboard.
module tb_bcp_clause_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cl_we = 1'b0;
  logic [3:0] cl_addr = '0;
  logic [7:0] cl_type = '0, cl_mask = '0;
  logic [7:0] asg_val = '0, asg_valid = '0;
  logic       start = 1'b0;
  logic       busy, done, all_sat, conflict;
  logic [3:0] conflict_clause;
  logic       imp_valid;
  logic       imp_ready = 1'b1;
  logic [2:0] imp_var;
  logic       imp_val;
  logic [3:0] imp_clause;
`ifdef BCP_STATS_EN
  logic [4:0] stat_unit_cnt, stat_sat_cnt;
`endif

  bcp_clause_scanner dut (
    .clock(clock), .reset(reset),
    .cl_we(cl_we), .cl_addr(cl_addr), .cl_type(cl_type), .cl_mask(cl_mask),
    .asg_val(asg_val), .asg_valid(asg_valid), .start(start),
    .busy(busy), .done(done), .all_sat(all_sat), .conflict(conflict),
    .conflict_clause(conflict_clause),
`ifdef BCP_STATS_EN
    .stat_unit_cnt(stat_unit_cnt), .stat_sat_cnt(stat_sat_cnt),
`endif
    .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_var(imp_var),
    .imp_val(imp_val), .imp_clause(imp_clause)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct { int v; logic val; int c; } exp_imp_t;
  exp_imp_t sbq[$];
  exp_imp_t sb_e;

  logic [7:0] mb_t [16];
  logic [7:0] mb_m [16];

  typedef struct {
    int a0; logic [7:0] t0, m0;
    int a1; logic [7:0] t1, m1;
    logic [7:0] val, vld;
    logic exp_sat, exp_conf; int exp_cc; int exp_cyc;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Accepted implications are matched in order against the reference model.
  always @(negedge clock) begin
    if (!reset && imp_valid && imp_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL imp_unexpected: got var=%0d clause=%0d expected none", imp_var, imp_clause);
      end else begin
        sb_e = sbq.pop_front();
        if (int'(imp_var) != sb_e.v || imp_val !== sb_e.val || int'(imp_clause) != sb_e.c) begin
          errors++;
          $display("FAIL imp_match: got var=%0d val=%0d clause=%0d expected var=%0d val=%0d clause=%0d",
                   imp_var, imp_val, imp_clause, sb_e.v, sb_e.val, sb_e.c);
        end
      end
    end
  end

  task automatic wr(input int a, input logic [7:0] t, input logic [7:0] m);
    cl_we = 1'b1; cl_addr = 4'(a); cl_type = t; cl_mask = m;
    @(posedge clock); #1;
    cl_we = 1'b0;
    mb_t[a] = t; mb_m[a] = m;
  endtask

  task automatic clear_bank();
    for (int i = 0; i < 16; i++) wr(i, 8'h00, 8'h00);
  endtask

  task automatic model_push(input logic [7:0] val, input logic [7:0] vld);
    for (int c = 0; c < 16; c++) begin
      logic [7:0] t, m;
      bit sat;
      int nopen, ov;
      t = mb_t[c]; m = mb_m[c]; sat = 0; nopen = 0; ov = 0;
      if (m == 8'h00) continue;
      for (int i = 0; i < 8; i++)
        if (m[i]) begin
          if (vld[i]) begin
            if (val[i] == t[i]) sat = 1;
          end else begin
            nopen++; ov = i;
          end
        end
      if (sat) continue;
      if (nopen == 0) break;
      if (nopen == 1) sbq.push_back('{ov, t[ov], c});
    end
  endtask

  task automatic run_scan(output int cyc);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic wait_imp(output int n);
    n = 0;
    while (!imp_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, n;
    vt[0] = '{0, 8'h03, 8'h03,  1, 8'h00, 8'h04, 8'h03, 8'h07, 1'b1, 1'b0, 0, 17};
    vt[1] = '{0, 8'h01, 8'h09,  1, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 0, 18};
    vt[2] = '{5, 8'h02, 8'h02,  0, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1, 5, 7};
    vt[3] = '{3, 8'hFF, 8'h03,  0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 17};
    vt[4] = '{15, 8'h81, 8'h81, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 0, 18};
    vt[5] = '{0, 8'h00, 8'h01,  1, 8'h02, 8'h02, 8'h01, 8'h01, 1'b0, 1'b1, 0, 2};
    vt[6] = '{2, 8'h04, 8'h0C,  9, 8'h00, 8'h08, 8'h08, 8'h08, 1'b0, 1'b1, 9, 12};
    vt[7] = '{0, 8'h01, 8'h01, 15, 8'h10, 8'h10, 8'h01, 8'h11, 1'b0, 1'b1, 15, 17};
    for (int i = 0; i < 16; i++) begin mb_t[i] = '0; mb_m[i] = '0; end

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs",
        32'({busy, done, all_sat, conflict, conflict_clause, imp_valid, imp_var, imp_val, imp_clause}), 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int v = 0; v < 8; v++) begin
      clear_bank();
      wr(vt[v].a0, vt[v].t0, vt[v].m0);
      wr(vt[v].a1, vt[v].t1, vt[v].m1);
      asg_val = vt[v].val; asg_valid = vt[v].vld;
      imp_ready = 1'b1;
      model_push(vt[v].val, vt[v].vld);
      run_scan(cyc);
      chk($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vt[v].exp_cyc));
      chk($sformatf("v%0d_all_sat", v), 32'(all_sat), 32'(vt[v].exp_sat));
      chk($sformatf("v%0d_conflict", v), 32'(conflict), 32'(vt[v].exp_conf));
      chk($sformatf("v%0d_conflict_clause", v), 32'(conflict_clause), 32'(vt[v].exp_cc));
      chk($sformatf("v%0d_sb_empty", v), 32'(sbq.size()), 32'd0);
    end

    // Implication held off for 5 cycles must stay stable.
    clear_bank();
    wr(0, 8'h01, 8'h09);
    asg_val = 8'h00; asg_valid = 8'h01; imp_ready = 1'b0;
    model_push(asg_val, asg_valid);
    start = 1'b1; @(posedge clock); #1; start = 1'b0;
    wait_imp(n);
    chk("hold_imp_seen", 32'(imp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      chk($sformatf("hold_stable_%0d", k), 32'({imp_valid, imp_var, imp_val, imp_clause, busy}),
          32'({1'b1, 3'd3, 1'b0, 4'd0, 1'b1}));
    end
    imp_ready = 1'b1;
    n = 0;
    while (!done && n < 300) begin @(posedge clock); #1; n++; end
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_all_sat", 32'(all_sat), 32'd0);
    chk("hold_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset while waiting in IMPLY.
    clear_bank();
    wr(0, 8'h01, 8'h09);
    imp_ready = 1'b0;
    model_push(asg_val, asg_valid);
    start = 1'b1; @(posedge clock); #1; start = 1'b0;
    wait_imp(n);
    chk("rst_imp_seen", 32'(imp_valid), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_outputs_low", 32'({imp_valid, busy, done}), 32'd0);
    sbq.delete();
    for (int i = 0; i < 16; i++) begin mb_t[i] = '0; mb_m[i] = '0; end
    @(posedge clock); #1;
    reset = 1'b0;
    imp_ready = 1'b1;
    run_scan(cyc);
    chk("rst_rescan_cycles", 32'(cyc), 32'd17);
    chk("rst_rescan_all_sat", 32'(all_sat), 32'd1);

    // start and cl_we during SCAN are dropped.
    wr(0, 8'h03, 8'h03);
    wr(1, 8'h00, 8'h04);
    asg_val = 8'h03; asg_valid = 8'h07;
    start = 1'b1; @(posedge clock); #1; start = 1'b0;
    cyc = 0;
    repeat (3) begin @(posedge clock); #1; cyc++; end
    start = 1'b1; cl_we = 1'b1; cl_addr = 4'd1; cl_type = 8'h04; cl_mask = 8'h04;
    @(posedge clock); #1; cyc++;
    start = 1'b0; cl_we = 1'b0;
    while (!done && cyc < 300) begin @(posedge clock); #1; cyc++; end
    chk("drop_cycles", 32'(cyc), 32'd17);
    chk("drop_all_sat", 32'(all_sat), 32'd1);
    run_scan(cyc);
    chk("drop_bank_conflict", 32'(conflict), 32'd0);
    chk("drop_bank_all_sat", 32'(all_sat), 32'd1);

`ifdef BCP_STATS_EN
    clear_bank();
    for (int i = 0; i < 3; i++) wr(i, 8'h01, 8'h01);
    for (int i = 3; i < 7; i++) wr(i, 8'h02, 8'h02);
    asg_val = 8'h02; asg_valid = 8'h02; imp_ready = 1'b1;
    model_push(asg_val, asg_valid);
    run_scan(cyc);
    chk("stat_cycles", 32'(cyc), 32'd20);
    chk("stat_unit_cnt", 32'(stat_unit_cnt), 32'd3);
    chk("stat_sat_cnt", 32'(stat_sat_cnt), 32'd4);
    chk("stat_all_sat", 32'(all_sat), 32'd0);
    chk("stat_sb_empty", 32'(sbq.size()), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcp_clause_scanner.md
# bcp_clause_scanner

Sequential clause evaluator for the hardware BCP engine, successor to the single-clause partial-satisfaction check. Holds a parametrised bank of clauses as type/mask pairs. On `start` it latches one assignment snapshot and scans the clauses one per cycle, classifying each clause as satisfied, unit or conflicting. Unit implications go out over a valid/ready handshake, and a conflict ends the scan; the external solver controller applies implications and re-runs the scan.

## Interface
- `VAR_NUM`, default 8: variables per clause vector.
- `CLAUSE_NUM`, default 16: clause slots, at least 2.
- `VIDX_W`, default `$clog2(VAR_NUM)`: variable index width.
- `CIDX_W`, default `$clog2(CLAUSE_NUM)`: clause index width.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `cl_we` in 1: clause write strobe; ignored while `busy`.
- `cl_addr` in CIDX_W: clause slot to write.
- `cl_type` in VAR_NUM: literal polarity per variable; 1 = positive, 0 = negated.
- `cl_mask` in VAR_NUM: variable present in the clause; an all-zero mask disables the slot.
- `asg_val` in VAR_NUM: assigned values.
- `asg_valid` in VAR_NUM: per-variable assigned flag.
- `start` in 1: begin a scan; ignored while `busy`.
- `busy` out 1: high in the SCAN and IMPLY states.
- `done` out 1: level, high in the DONE state.
- `all_sat` out 1: valid while `done`; every enabled clause was satisfied.
- `conflict` out 1: valid while `done`; the scan hit a conflicting clause.
- `conflict_clause` out CIDX_W: index of the conflicting clause.
- `imp_valid` out 1: implication offered.
- `imp_ready` in 1: implication accepted.
- `imp_var` out VIDX_W: implied variable.
- `imp_val` out 1: implied value, equal to `cl_type` of that variable.
- `imp_clause` out CIDX_W: clause that produced the implication.

## Operation
- Clause bank: CLAUSE_NUM × (type, mask) flops, cleared to 0 by `reset`. A write takes effect on the clock edge.
- Literal classification, for each variable i with mask[i]=1:
  - true: valid[i] && val[i]==type[i].
  - false: valid[i] && val[i]!=type[i].
  - open: !valid[i].
- Clause classes, evaluated in this priority order:
  - disabled: mask==0.
  - sat: any literal true.
  - conflict: no open literals.
  - unit: exactly one open literal.
  - undecided: two or more open literals.
- FSM states: IDLE, SCAN, IMPLY, DONE.
  - IDLE/DONE, `start`: latch `asg_val`/`asg_valid` into a snapshot, set idx=0, clear `done`/`all_sat`/`conflict`, go to SCAN.
  - SCAN, clause idx disabled, sat or undecided: advance. Undecided clears the running all_sat flag.
  - SCAN, unit: go to IMPLY. Register `imp_var`, `imp_val` and `imp_clause`=idx; `imp_valid`=1 from the next cycle. Clear the running all_sat flag.
  - IMPLY: hold all imp outputs stable until `imp_valid && imp_ready`, then drop `imp_valid` and advance.
  - SCAN, conflict: go to DONE, `conflict`=1, `conflict_clause`=idx. The remaining clauses are not scanned.
  - Advance: if idx==CLAUSE_NUM-1, go to DONE with `all_sat` = running flag; else idx+1 and go to SCAN.
- The scan uses only the snapshot. Implications are reported, never applied internally; duplicate implications are legal.
- `start` while `busy` and `cl_we` while `busy` are dropped with no effect.
- `reset` mid-scan: immediately go to IDLE and clear every output and the clause bank.

## Timing
- Reset values: all outputs 0, state IDLE.
- `start` sampled at edge 0. `busy`=1 after edge 0.
- Clause k is evaluated in SCAN cycle k+1 when no implication stalls occur.
- With no unit clauses, `done` rises after edge CLAUSE_NUM+1.
- Each implication adds 1 cycle to reach IMPLY, plus its handshake wait; with `imp_ready` tied high the cost is 1 extra cycle per unit clause.
- `imp_valid` is registered. `imp_ready` may be high before `imp_valid`.
- `done` holds until the next accepted `start` or `reset`.

## Configuration
- `BCP_STATS_EN` defined: adds outputs `stat_unit_cnt` and `stat_sat_cnt`, each CIDX_W+1 bits.
  - Both are zeroed on an accepted `start`.
  - They increment per unit or sat clause scanned and hold in DONE.
  - They reset to 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Clauses 0=(x0∨x1): type 0x03, mask 0x03; 1=(¬x2): type 0x00, mask 0x04; others disabled. Asg val=0x03, valid=0x07, `start` -> `done` at cycle 17, `all_sat`=1, `conflict`=0, no `imp_valid`.
- Clause 0=(x0∨¬x3): type 0x01, mask 0x09. Asg valid=0x01, val=0x00 -> `imp_valid`, `imp_var`=3, `imp_val`=0, `imp_clause`=0. Hold `imp_ready`=0 for 5 cycles: outputs stay stable. Then accept -> scan resumes; at `done`, `all_sat`=0.
- Clause 5=(x1): type 0x02, mask 0x02. Asg valid=0x02, val=0x00 -> `done` with `conflict`=1, `conflict_clause`=5, `busy` falls 7 cycles after `start`.
- Assert `reset` in IMPLY -> `imp_valid`, `busy` and `done` are 0 the same cycle; a rescan shows all slots disabled, so `all_sat`=1.
- `start` and `cl_we` pulsed during SCAN -> both ignored; the clause bank is unchanged and the scan length is still 17 cycles.
- `BCP_STATS_EN`: 3 unit and 4 sat clauses with `imp_ready`=1 -> `stat_unit_cnt`=3, `stat_sat_cnt`=4, `done` at cycle 20.
